// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and types for the PS/2 Set-2 key tracker.
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;
    localparam int         EVT_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic       make;
        logic [8:0] code;
    } evt_t;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Key event stream: valid/ready handshake carrying {ext,code} and make flag.
interface ps2_key_tracker_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [8:0] evt_code;
    logic       evt_make;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_make,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_make,
        output evt_ready
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code sequencer with key-table lookup, typematic suppression,
// pressed bitmap and a queued make/break event stream.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_TABLE      =
        {9'h01D, 9'h01B, 9'h01C, 9'h023},
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT_CYCLES = 2_000_000,
    parameter bit                    REPORT_ALL     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          din,
    input  logic                scan_done_tick,
    ps2_key_tracker_if.master   evt,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    state_t        state_nx;
    logic [2:0]    skip;
    logic [2:0]    skip_nx;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    logic          done;
    logic          code_ext;
    logic          is_make;
    logic [8:0]    full_code;

    logic [NUM_KEYS-1:0] hit;
    logic          any_hit;
    logic          repeat_make;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    evt_t          evt_in;
    evt_t          evt_out;

    assign tmo_hit = (state != ST_IDLE) && !scan_done_tick &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            skip  <= '0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        done     = 1'b0;
        code_ext = 1'b0;
        is_make  = 1'b0;
        if (scan_done_tick) begin
            unique case (state)
                ST_IDLE: begin
                    unique case (1'b1)
                        din == PS2_EXT: state_nx = ST_EXT;
                        din == PS2_BRK: state_nx = ST_BRK;
                        din == PS2_PAUSE: begin
                            state_nx = ST_SKIP;
                            skip_nx  = PAUSE_TAIL;
                        end
                        default: begin
                            done    = 1'b1;
                            is_make = 1'b1;
                        end
                    endcase
                end
                ST_EXT: begin
                    unique case (1'b1)
                        din == PS2_BRK: state_nx = ST_EXT_BRK;
                        din == PS2_EXT: state_nx = ST_EXT;
                        default: begin
                            done     = 1'b1;
                            is_make  = 1'b1;
                            code_ext = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    endcase
                end
                ST_BRK: begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    done     = 1'b1;
                    code_ext = 1'b1;
                    state_nx = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_nx = skip - 3'd1;
                    if (skip == 3'd1) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nx = ST_IDLE;
        end
    end

    // Idle-time watchdog so a lost byte cannot leave a prefix pending forever
    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE || scan_done_tick || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign full_code = {code_ext, din};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lookup
        assign hit[i] =
            (KEY_TABLE[(NUM_KEYS-1-i)*9 +: 9] == full_code);
    end

    assign any_hit     = |hit;
    assign repeat_make = |(hit & key_state);

    always_comb begin
        push = 1'b0;
        if (done) begin
            if (is_make) push = !repeat_make && (any_hit || REPORT_ALL);
            else         push = any_hit || REPORT_ALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_state <= '0;
        end else if (done) begin
            if (is_make) key_state <= key_state | hit;
            else         key_state <= key_state & ~hit;
        end
    end

    assign pop = evt.evt_valid & evt.evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign evt_in.make = is_make;
    assign evt_in.code = full_code;

    ps2_event_fifo #(
        .WIDTH(EVT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  (evt_in),
        .full (fifo_full),
        .pop  (pop),
        .dout (evt_out),
        .empty(fifo_empty)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_code  = evt_out.code;
    assign evt.evt_make  = evt_out.make;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios plus random byte streams
// checked against a sequence-level reference model.
module tb_ps2_key_tracker;

    localparam int TO    = 100;
    localparam int DEPTH = 4;
    localparam bit RA    = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       scan_done_tick;
    logic [3:0] key_state;
    logic       overflow;

    ps2_key_tracker_if evt();

    always #5 clk = ~clk;

    ps2_key_tracker #(
        .NUM_KEYS(4),
        .KEY_TABLE({9'h01D, 9'h01B, 9'h01C, 9'h023}),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO),
        .REPORT_ALL(RA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .scan_done_tick(scan_done_tick),
        .evt(evt),
        .key_state(key_state),
        .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] keys [4] = '{9'h01D, 9'h01B, 9'h01C, 9'h023};
    bit         pressed [4];
    logic [9:0] mq [$];
    bit         m_ovf;
    bit         m_ext;
    bit         m_brk;
    int         m_skip;
    int         m_wait;

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) pressed[i] = 1'b0;
        mq.delete();
        m_ovf  = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
        m_wait = 0;
    endfunction

    function automatic logic [3:0] m_ks();
        logic [3:0] k;
        for (int i = 0; i < 4; i++) k[i] = pressed[i];
        return k;
    endfunction

    // Applies a completed code to the pressed table; returns whether to queue.
    function automatic bit complete(input logic [8:0] c, input bit mk,
                                    output logic [9:0] e);
        bit h   = 1'b0;
        bit rep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i] == c) begin
                h = 1'b1;
                if (mk && pressed[i]) rep = 1'b1;
                pressed[i] = mk;
            end
        end
        e = {mk, c};
        return (h || RA) && !rep;
    endfunction

    function automatic void model_cycle(bit t, logic [7:0] b, bit r);
        bit pop = r && (mq.size() != 0);
        bit have = 1'b0;
        logic [9:0] e = '0;
        if (t) begin
            m_wait = 0;
            if (m_skip > 0) m_skip--;
            else if (m_brk) begin
                have  = complete({m_ext, b}, 1'b0, e);
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hE1 && !m_ext) m_skip = 7;
            else begin
                have  = complete({m_ext, b}, 1'b1, e);
                m_ext = 1'b0;
            end
        end else if (m_ext || m_brk || m_skip > 0) begin
            m_wait++;
            if (m_wait >= TO) begin
                m_ext  = 1'b0;
                m_brk  = 1'b0;
                m_skip = 0;
                m_wait = 0;
            end
        end
        if (have && !(mq.size() < DEPTH || pop)) begin
            m_ovf = 1'b1;
            have  = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (have) mq.push_back(e);
    endfunction

    task automatic step(input bit t, input logic [7:0] b, input bit r);
        scan_done_tick = t;
        din            = b;
        evt.evt_ready  = r;
        model_cycle(t, b, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        scan_done_tick = 1'b0;
        din            = 8'h00;
        evt.evt_ready  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (evt.evt_valid !== 1'b0 || evt.evt_code !== 9'h000 ||
            evt.evt_make !== 1'b0) begin
            errors++;
            $display("FAIL reset_evt got v=%0b c=%h m=%0b exp 0/000/0",
                     evt.evt_valid, evt.evt_code, evt.evt_make);
        end
        checks++;
        if (key_state !== 4'b0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ks=%b ov=%0b exp 0000/0",
                     key_state, overflow);
        end
    endtask

    task automatic test_make_break();
        step(1'b1, 8'h1D, 1'b1);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h01D ||
            evt.evt_make !== 1'b1 || key_state !== 4'b0001) begin
            errors++;
            $display("FAIL mb_make got v=%0b c=%h m=%0b ks=%b exp 1/01d/1/0001",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (evt.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mb_pop got v=%0b exp 0", evt.evt_valid);
        end
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h1D, 1'b1);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h01D ||
            evt.evt_make !== 1'b0 || key_state !== 4'b0000) begin
            errors++;
            $display("FAIL mb_break got v=%0b c=%h m=%0b ks=%b exp 1/01d/0/0000",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_extended();
        step(1'b1, 8'hE0, 1'b1);
        step(1'b1, 8'h75, 1'b1);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h175 ||
            evt.evt_make !== 1'b1 || key_state !== 4'b0000) begin
            errors++;
            $display("FAIL ext_make got v=%0b c=%h m=%0b ks=%b exp 1/175/1/0000",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hE0, 1'b1);
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h75, 1'b1);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h175 ||
            evt.evt_make !== 1'b0 || key_state !== 4'b0000) begin
            errors++;
            $display("FAIL ext_break got v=%0b c=%h m=%0b ks=%b exp 1/175/0/0000",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_typematic();
        logic [9:0] got [8];
        int n = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'h1D, 1'b0);
        checks++;
        if (key_state !== 4'b0001) begin
            errors++;
            $display("FAIL typ_held got ks=%b exp 0001", key_state);
        end
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h1D, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (evt.evt_valid === 1'b1 && n < 8) begin
                got[n] = {evt.evt_make, evt.evt_code};
                n++;
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (n != 2 || got[0] !== 10'h21D || got[1] !== 10'h01D) begin
            errors++;
            $display("FAIL typ_events got n=%0d e0=%h e1=%h exp 2/21d/01d",
                     n, got[0], got[1]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6] = '{8'h15, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
        logic [9:0] exp_e [4] = '{10'h215, 10'h224, 10'h22D, 10'h22C};
        logic [9:0] got [8];
        int n = 0;
        for (int i = 0; i < 6; i++) step(1'b1, b[i], 1'b0);
        checks++;
        if (overflow !== 1'b1 || evt.evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got ov=%0b v=%0b exp 1/1",
                     overflow, evt.evt_valid);
        end
        for (int i = 0; i < 7; i++) begin
            if (evt.evt_valid === 1'b1 && n < 8) begin
                got[n] = {evt.evt_make, evt.evt_code};
                n++;
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL ovf_count got %0d exp 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < n && got[i] !== exp_e[i]) begin
                errors++;
                $display("FAIL ovf_order[%0d] got %h exp %h",
                         i, got[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] b [4] = '{8'h15, 8'h24, 8'h2D, 8'h2C};
        logic [9:0] exp_e [4] = '{10'h224, 10'h22D, 10'h22C, 10'h235};
        logic [9:0] got [8];
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, b[i], 1'b0);
        step(1'b1, 8'h35, 1'b1);
        checks++;
        if (overflow !== 1'b0 || evt.evt_valid !== 1'b1 ||
            evt.evt_code !== 9'h024) begin
            errors++;
            $display("FAIL fp_accept got ov=%0b v=%0b c=%h exp 0/1/024",
                     overflow, evt.evt_valid, evt.evt_code);
        end
        for (int i = 0; i < 7; i++) begin
            if (evt.evt_valid === 1'b1 && n < 8) begin
                got[n] = {evt.evt_make, evt.evt_code};
                n++;
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (n != 4 || got[0] !== exp_e[0] || got[1] !== exp_e[1] ||
            got[2] !== exp_e[2] || got[3] !== exp_e[3]) begin
            errors++;
            $display("FAIL fp_drain got n=%0d %h %h %h %h exp 4 224 22d 22c 235",
                     n, got[0], got[1], got[2], got[3]);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] =
            '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) step(1'b1, seq[i], 1'b0);
        checks++;
        if (evt.evt_valid !== 1'b0 || key_state !== 4'b0000) begin
            errors++;
            $display("FAIL pause_quiet got v=%0b ks=%b exp 0/0000",
                     evt.evt_valid, key_state);
        end
        step(1'b1, 8'h1C, 1'b0);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h01C ||
            evt.evt_make !== 1'b1 || key_state !== 4'b0100) begin
            errors++;
            $display("FAIL pause_next got v=%0b c=%h m=%0b ks=%b exp 1/01c/1/0100",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_timeout();
        step(1'b1, 8'hE0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h23, 1'b0);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h123) begin
            errors++;
            $display("FAIL tmo_held got v=%0b c=%h exp 1/123",
                     evt.evt_valid, evt.evt_code);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hE0, 1'b0);
        for (int i = 0; i < TO + 5; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h1B, 1'b0);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h01B ||
            evt.evt_make !== 1'b1 || key_state !== 4'b0110) begin
            errors++;
            $display("FAIL tmo_expire got v=%0b c=%h m=%0b ks=%b exp 1/01b/1/0110",
                     evt.evt_valid, evt.evt_code, evt.evt_make, key_state);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hE0, 1'b0);
        do_reset();
        checks++;
        if (evt.evt_valid !== 1'b0 || evt.evt_code !== 9'h000 ||
            key_state !== 4'b0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got v=%0b c=%h ks=%b ov=%0b exp 0/000/0000/0",
                     evt.evt_valid, evt.evt_code, key_state, overflow);
        end
        step(1'b1, 8'h75, 1'b0);
        checks++;
        if (evt.evt_valid !== 1'b1 || evt.evt_code !== 9'h075) begin
            errors++;
            $display("FAIL rmid_plain got v=%0b c=%h exp 1/075",
                     evt.evt_valid, evt.evt_code);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h1D, 8'h75,
                                  8'h15, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h2C};
        logic [9:0] head;
        bit t;
        bit r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            t = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            step(t, pool[$urandom_range(0, 11)], r);
            checks++;
            if (evt.evt_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid@%0d got %0b exp %0b",
                         i, evt.evt_valid, mq.size() != 0);
            end else if (mq.size() != 0) begin
                head = mq[0];
                checks++;
                if ({evt.evt_make, evt.evt_code} !== head) begin
                    errors++;
                    $display("FAIL rnd_head@%0d got %h exp %h",
                             i, {evt.evt_make, evt.evt_code}, head);
                end
            end
            checks++;
            if (key_state !== m_ks() || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_state@%0d got ks=%b ov=%0b exp %b/%0b",
                         i, key_state, overflow, m_ks(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_typematic();
        test_overflow();
        test_full_pop();
        test_pause();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
